// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, data-bus wait states with
// timeout abort, branch/jump flushes and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_addr_rd,
    input  logic             ex_reg_wr_en,
    input  logic             ex_is_load,
    input  logic             jump_en,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             hold_n_pc,
    output logic             hold_n_if_id,
    output logic             hold_n_id_ex,
    output logic             hold_n_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        flush_q, flush_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  stall_q;
    logic              mem_stall;
    logic              load_use;

    assign mem_stall = mem_req & ~mem_ack;
    assign load_use  = ex_is_load & ex_reg_wr_en & (ex_addr_rd != 5'd0) &
                       ((id_rs1_used & (id_rs1_addr == ex_addr_rd)) |
                        (id_rs2_used & (id_rs2_addr == ex_addr_rd)));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        flush_d       = flush_q;
        bus_err_d     = 1'b0;
        hold_n_pc     = 1'b1;
        hold_n_if_id  = 1'b1;
        hold_n_id_ex  = 1'b1;
        hold_n_ex_mem = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = '0;
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else if (jump_en) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            flush_d = 3'(FLUSH_CYCLES - 1);
                        end
                    end else if (load_use) begin
                        hold_n_pc    = 1'b0;
                        hold_n_if_id = 1'b0;
                        flush_id_ex  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // wait_q counts stalled cycles so far; at the limit the holds
                    // release and the abort is flagged instead of stalling again
                    if (mem_ack) begin
                        state_d = RUN;
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        bus_err_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = '0;
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                FLUSH: begin
                    if (mem_stall) begin
                        {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem} = '0;
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        if (jump_en) begin
                            flush_d = 3'(FLUSH_CYCLES - 1);
                        end else begin
                            flush_d = flush_q - 3'd1;
                            if (flush_q == 3'd1) state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            flush_q   <= '0;
            bus_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            flush_q   <= flush_d;
            bus_err_q <= bus_err_d;
            if (!hold_n_pc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MEM_TIMEOUT=4, FLUSH_CYCLES=2, CNT_W=4.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_addr_rd;
    logic       id_rs1_used, id_rs2_used, ex_reg_wr_en, ex_is_load;
    logic       jump_en, mem_req, mem_ack;
    logic       hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem;
    logic       flush_if_id, flush_id_ex, bus_err;
    logic [3:0] stall_cnt;
    logic [3:0] holds;
    logic [1:0] fl;
    int         checks = 0;
    int         errors = 0;

    pipe_ctrl #(.MEM_TIMEOUT(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_addr_rd(ex_addr_rd), .ex_reg_wr_en(ex_reg_wr_en), .ex_is_load(ex_is_load),
        .jump_en(jump_en), .mem_req(mem_req), .mem_ack(mem_ack),
        .hold_n_pc(hold_n_pc), .hold_n_if_id(hold_n_if_id),
        .hold_n_id_ex(hold_n_id_ex), .hold_n_ex_mem(hold_n_ex_mem),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign holds = {hold_n_pc, hold_n_if_id, hold_n_id_ex, hold_n_ex_mem};
    assign fl    = {flush_if_id, flush_id_ex};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] h, input logic [1:0] f);
        chk({tag, "_hold"}, {28'd0, holds}, {28'd0, h});
        chk({tag, "_flush"}, {30'd0, fl}, {30'd0, f});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_addr_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_reg_wr_en = 1'b0; ex_is_load = 1'b0;
        jump_en = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_is_load = 1'b1; ex_reg_wr_en = 1'b1; ex_addr_rd = rd;
        id_rs2_used = 1'b1; id_rs2_addr = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1; mem_req = 1'b1; jump_en = 1'b1;
        #1 expect_out("rst_comb", 4'b1111, 2'b00);
        tick(); tick();
        expect_out("rst_hold", 4'b1111, 2'b00);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_berr", {31'd0, bus_err}, 32'd0);
        rst = 1'b0; idle();
        #1 expect_out("run_idle", 4'b1111, 2'b00);
        tick();

        // load-use via rs2: single bubble
        set_load_use(5'd5);
        #1 expect_out("lu_rs2", 4'b0011, 2'b01);
        tick(); idle();
        #1 expect_out("lu_after", 4'b1111, 2'b00);
        chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);
        set_load_use(5'd0);
        #1 expect_out("lu_x0", 4'b1111, 2'b00);
        tick(); idle();
        id_rs1_used = 1'b1; id_rs1_addr = 5'd7; ex_addr_rd = 5'd7;
        ex_is_load = 1'b1; ex_reg_wr_en = 1'b1;
        #1 expect_out("lu_rs1", 4'b0011, 2'b01);
        tick();
        ex_reg_wr_en = 1'b0;
        #1 expect_out("lu_nowr", 4'b1111, 2'b00);
        chk("lu_cnt2", {28'd0, stall_cnt}, 32'd2);
        tick(); idle();

        // memory wait, ack on 4th cycle
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 expect_out("mw_stall", 4'b0000, 2'b00);
            tick();
        end
        mem_ack = 1'b1;
        #1 expect_out("mw_ack", 4'b1111, 2'b00);
        tick(); idle();
        #1 chk("mw_cnt", {28'd0, stall_cnt}, 32'd5);
        chk("mw_berr", {31'd0, bus_err}, 32'd0);

        // timeout: 4 stalled cycles then abort
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 expect_out("to_stall", 4'b0000, 2'b00);
            tick();
        end
        #1 expect_out("to_abort", 4'b1111, 2'b00);
        chk("to_berr_pre", {31'd0, bus_err}, 32'd0);
        tick(); idle();
        #1 chk("to_berr", {31'd0, bus_err}, 32'd1);
        expect_out("to_run", 4'b1111, 2'b00);
        tick();
        chk("to_berr_off", {31'd0, bus_err}, 32'd0);
        chk("to_cnt", {28'd0, stall_cnt}, 32'd9);

        // jump beats load-use, flush lasts 2 cycles
        set_load_use(5'd3); jump_en = 1'b1;
        #1 expect_out("jmp_c1", 4'b1111, 2'b11);
        tick(); jump_en = 1'b0;
        #1 expect_out("jmp_c2", 4'b1111, 2'b11);
        tick(); idle();
        #1 expect_out("jmp_c3", 4'b1111, 2'b00);
        chk("jmp_cnt", {28'd0, stall_cnt}, 32'd9);

        // jump reload inside FLUSH
        jump_en = 1'b1;
        #1 expect_out("rl_c1", 4'b1111, 2'b11);
        tick();
        #1 expect_out("rl_c2", 4'b1111, 2'b11);
        tick(); jump_en = 1'b0;
        #1 expect_out("rl_c3", 4'b1111, 2'b11);
        tick();
        #1 expect_out("rl_c4", 4'b1111, 2'b00);

        // memory wait arriving in FLUSH
        jump_en = 1'b1;
        #1 expect_out("fm_c1", 4'b1111, 2'b11);
        tick(); jump_en = 1'b0; mem_req = 1'b1;
        #1 expect_out("fm_c2", 4'b0000, 2'b00);
        tick(); mem_ack = 1'b1;
        #1 expect_out("fm_c3", 4'b1111, 2'b00);
        tick(); idle();
        #1 chk("fm_cnt", {28'd0, stall_cnt}, 32'd10);

        // memory wait beats jump; jump ignored in MEM_WAIT
        mem_req = 1'b1; jump_en = 1'b1;
        #1 expect_out("pr_c1", 4'b0000, 2'b00);
        tick(); mem_ack = 1'b1;
        #1 expect_out("pr_c2", 4'b1111, 2'b00);
        tick(); idle();
        #1 expect_out("pr_c3", 4'b1111, 2'b00);
        chk("pr_cnt", {28'd0, stall_cnt}, 32'd11);

        // zero-wait access
        mem_req = 1'b1; mem_ack = 1'b1;
        #1 expect_out("zw", 4'b1111, 2'b00);
        tick(); idle();
        #1 chk("zw_cnt", {28'd0, stall_cnt}, 32'd11);

        // reset mid-MEM_WAIT gives no bus_err
        mem_req = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1 expect_out("rmw_comb", 4'b1111, 2'b00);
        tick(); rst = 1'b0; idle();
        #1 expect_out("rmw_run", 4'b1111, 2'b00);
        chk("rmw_cnt", {28'd0, stall_cnt}, 32'd0);
        tick();
        chk("rmw_berr", {31'd0, bus_err}, 32'd0);

        // saturation: 20 consecutive load-use stalls
        set_load_use(5'd9);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat", {28'd0, stall_cnt}, (i < 15) ? i : 15);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It generates the per-stage hold_n write enables and flush strobes consumed by the pc, if_id, id_ex and ex_mem pipeline registers. It covers three cases: load-use hazards, data-bus wait states with a timeout, and branch/jump flushes. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before the bus-error abort (>=1)
FLUSH_CYCLES, 1, number of cycles flush strobes stay asserted after a jump (1..7)
CNT_W, 32, width of the stall counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
id_rs1_addr  in  5  rs1 index of the instruction in ID
id_rs2_addr  in  5  rs2 index of the instruction in ID
id_rs1_used  in  1  instruction in ID reads rs1
id_rs2_used  in  1  instruction in ID reads rs2
ex_addr_rd  in  5  rd of the instruction in EX (addr_rd out of id_ex)
ex_reg_wr_en  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load (load code != LOAD_NOPE)
jump_en  in  1  EX resolved a taken branch or jump this cycle
mem_req  in  1  MEM stage has an active data-bus request
mem_ack  in  1  data-bus response valid
hold_n_pc  out  1  0 = freeze pc
hold_n_if_id  out  1  0 = freeze if_id
hold_n_id_ex  out  1  0 = freeze id_ex
hold_n_ex_mem  out  1  0 = freeze ex_mem
flush_if_id  out  1  1 = load bubble into if_id
flush_id_ex  out  1  1 = load bubble into id_ex
bus_err  out  1  one-cycle pulse on MEM_WAIT timeout
stall_cnt  out  CNT_W  saturating count of cycles with hold_n_pc=0

Behaviour:
- States: RUN, MEM_WAIT, FLUSH. The state register, wait counter, flush counter and stall_cnt are registered. hold_n and flush outputs are combinational from the current state and inputs, so they take effect in the same cycle.
- Reset (rst=1 at a clk edge): state=RUN, counters=0, bus_err=0.
  - While rst is high, all hold_n are forced to 1 and all flush outputs to 0.
  - Reset mid-MEM_WAIT or mid-FLUSH aborts immediately; no bus_err is produced.
- Default outputs (RUN, no event): all hold_n=1, flush=0.
- Priority inside RUN: memory wait > jump > load-use.
- Memory wait, RUN with mem_req=1 and mem_ack=0:
  - All four hold_n=0 and flush=0 this cycle.
  - Next state MEM_WAIT; the wait counter loads 1.
  - mem_req=1 with mem_ack=1 in the same cycle is a zero-wait access: no stall.
- MEM_WAIT:
  - All hold_n stay 0.
  - If mem_ack=1: holds release in that same cycle; next state RUN.
  - Otherwise the wait counter increments. When it equals MEM_TIMEOUT with no ack: bus_err=1 for exactly one cycle (registered, visible the cycle after), next state RUN, holds release.
  - jump_en and the hazard inputs are ignored in MEM_WAIT.
- Jump, RUN with jump_en=1 and no memory wait:
  - flush_if_id=1 and flush_id_ex=1 immediately; all hold_n=1.
  - If FLUSH_CYCLES>1, go to FLUSH with the flush counter = FLUSH_CYCLES-1. FLUSH keeps both flushes high and decrements each cycle; at 0, return to RUN.
  - jump_en=1 in FLUSH reloads the counter.
  - A memory wait arriving in FLUSH moves to MEM_WAIT; flushes drop while frozen.
- Load-use, RUN with no memory wait and no jump, when all of the following hold:
  - ex_is_load=1, ex_reg_wr_en=1, ex_addr_rd!=0;
  - and either (id_rs1_used && id_rs1_addr==ex_addr_rd) or (id_rs2_used && id_rs2_addr==ex_addr_rd).
  - Then hold_n_pc=0, hold_n_if_id=0, flush_id_ex=1; hold_n_id_ex=1 and hold_n_ex_mem=1.
  - Exactly one bubble results: next cycle the load has left EX, so detection clears. No state change.
- A jump takes precedence over a load-use in the same cycle, because the ID instruction is being flushed anyway.
- Register x0 never creates a hazard.
- stall_cnt: increments on every cycle with hold_n_pc=0 (outside reset) and saturates at all-ones.

Test Plan:
- Reset: hold rst=1 for 2 cycles with mem_req=1 and jump_en=1 -> all hold_n=1, flush=0, stall_cnt=0, bus_err=0; after release, state is RUN.
- Load-use: ex_is_load=1, ex_reg_wr_en=1, ex_addr_rd=5, id_rs2_used=1, id_rs2_addr=5 for one cycle -> hold_n_pc=0, hold_n_if_id=0, flush_id_ex=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_addr_rd=0 -> no stall.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 -> all hold_n=0 for 3 cycles, released on the ack cycle; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ack never -> holds low 4 cycles, bus_err=1 for exactly 1 cycle, then return to RUN.
- Jump with FLUSH_CYCLES=2: jump_en=1 for one cycle while the load-use condition is also true -> both flushes high for 2 cycles, hold_n_pc stays 1, no load-use stall.
- Priority and saturation: mem_req=1, mem_ack=0 and jump_en=1 together -> freeze wins, no flush. With CNT_W=4, 20 stall cycles -> stall_cnt=15.
